// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store controller:
// RISC-V width codes, FSM states, beat limits and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int MAX_BEATS = 4;
  localparam int BEAT_W    = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } lsu_state_t;

  // Number of byte beats for a width code; 0 marks an unknown code.
  function automatic logic [2:0] beats_for(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: beats_for = 3'd1;
      F3_LH, F3_LHU: beats_for = 3'd2;
      F3_LW:         beats_for = 3'd4;
      default:       beats_for = 3'd0;
    endcase
  endfunction

  // Unsigned variants only exist for loads.
  function automatic logic funct3_legal(input logic [2:0] funct3, input logic we);
    funct3_legal = (beats_for(funct3) != 3'd0) && !(we && funct3[2]);
  endfunction

  // Natural-alignment test, only consulted when the misalignment trap is built in.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_LH, F3_LHU: is_misaligned = addr_lo[0];
      F3_LW:         is_misaligned = (addr_lo != 2'b00);
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

  // Byte idx of a 32-bit word, idx 0 being bits [7:0].
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_ctrl_if.sv
// Pipeline request/response and byte-memory port bundle for lsu_byte_ctrl.
// slave: the controller's view; master: the pipeline/memory side.
interface lsu_byte_ctrl_if #(parameter int ADDR_W = 32) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of the assembled load bytes according to the width code.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  // Pick the extension from the low byte/half of the accumulator.
  always_comb begin
    result = acc;
    case (funct3)
      F3_LB:   result = {{24{acc[7]}}, acc[7:0]};
      F3_LBU:  result = {24'h000000, acc[7:0]};
      F3_LH:   result = {{16{acc[15]}}, acc[15:0]};
      F3_LHU:  result = {16'h0000, acc[15:0]};
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/lsu_byte_ctrl.sv
// Byte-serial load/store controller: one request at a time, split into
// 1/2/4 big-endian byte beats on a byte-wide memory port.
// Optional build macro LSU_MISALIGN_TRAP_EN rejects misaligned H/W accesses.
module lsu_byte_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  lsu_byte_ctrl_if.slave bus
);

  lsu_state_t        state_reg;
  logic              we_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic [23:0]       acc_reg;
  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic              resp_err_reg;
  logic [31:0]       resp_rdata_reg;
  logic              mem_re_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [7:0]        mem_wdata_reg;

  logic              accept;
  logic              reject;
  logic [2:0]        n_beats;
  logic              last_beat;
  logic [BEAT_W-1:0] beat_next;
  logic [31:0]       acc_next;
  logic [31:0]       ext_result;
  logic [1:0]        first_byte_idx;
  logic [1:0]        next_byte_idx;

  assign accept = bus.req_valid && req_ready_reg;

`ifdef LSU_MISALIGN_TRAP_EN
  assign reject = !funct3_legal(bus.req_funct3, bus.req_we) ||
                  is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign reject = !funct3_legal(bus.req_funct3, bus.req_we);
`endif

  assign n_beats        = beats_for(funct3_reg);
  assign last_beat      = (3'(beat_reg) == n_beats - 3'd1);
  assign beat_next      = beat_reg + 1'b1;
  // Lowest address is the most significant byte: shift each read byte in at the bottom.
  assign acc_next       = {acc_reg, bus.mem_rdata};
  // Store beat k sends byte (N-1-k); these are the indices for the first and following beat.
  assign first_byte_idx = 2'(beats_for(bus.req_funct3) - 3'd1);
  assign next_byte_idx  = 2'(n_beats - 3'd2 - 3'(beat_reg));

  lsu_load_extend u_extend (
    .acc    (acc_next),
    .funct3 (funct3_reg),
    .result (ext_result)
  );

  // Controller FSM with all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      we_reg         <= 1'b0;
      funct3_reg     <= 3'b000;
      addr_reg       <= '0;
      wdata_reg      <= 32'h0;
      beat_reg       <= '0;
      acc_reg        <= 24'h0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'h0;
      mem_re_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            we_reg        <= bus.req_we;
            funct3_reg    <= bus.req_funct3;
            addr_reg      <= bus.req_addr;
            wdata_reg     <= bus.req_wdata;
            beat_reg      <= '0;
            acc_reg       <= 24'h0;
            req_ready_reg <= 1'b0;
            if (reject) begin
              state_reg      <= ST_RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= 32'h0;
            end else begin
              state_reg     <= ST_ACCESS;
              mem_re_reg    <= !bus.req_we;
              mem_we_reg    <= bus.req_we;
              mem_addr_reg  <= bus.req_addr;
              mem_wdata_reg <= bus.req_we ? byte_sel(bus.req_wdata, first_byte_idx) : 8'h00;
            end
          end
        end
        ST_ACCESS: begin
          if (!we_reg) begin
            acc_reg <= acc_next[23:0];
          end
          if (last_beat) begin
            state_reg      <= ST_RESP;
            mem_re_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= we_reg ? 32'h0 : ext_result;
          end else begin
            beat_reg      <= beat_next;
            mem_addr_reg  <= addr_reg + ADDR_W'(beat_next);
            mem_wdata_reg <= we_reg ? byte_sel(wdata_reg, next_byte_idx) : 8'h00;
          end
        end
        ST_RESP: begin
          state_reg      <= ST_IDLE;
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          req_ready_reg  <= 1'b1;
        end
        default: begin
          state_reg     <= ST_IDLE;
          mem_re_reg    <= 1'b0;
          mem_we_reg    <= 1'b0;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.mem_re     = mem_re_reg;
  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_byte_ctrl.sv
// Directed bench for lsu_byte_ctrl with a 256-byte memory model (low address bits).
module tb_lsu_byte_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  lsu_byte_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_byte_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model; writes are qualified by reset so a beat cut off by reset is not stored.
  logic [7:0] mem [0:255];
  logic       pre_en;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  assign bus.mem_rdata = bus.mem_re ? mem[bus.mem_addr[7:0]] : 8'h00;

  // Preload port and DUT byte writes.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.mem_we && !rst) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issue one request at a negedge and follow it cycle by cycle.
  // exp_wbytes holds the expected store bytes in beat order from bit 31 down.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int n, input logic exp_err,
                         input logic [31:0] exp_rdata, input logic [31:0] exp_wbytes);
    check_val("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(negedge clk);
    // Keep a bogus request pending through ACCESS and RESP; it must be ignored.
    bus.req_we = 1'b0; bus.req_funct3 = 3'b011; bus.req_addr = 32'h0;
    for (int k = 0; k < n; k++) begin
      check_val("beat_re",   32'(bus.mem_re), 32'(!we));
      check_val("beat_we",   32'(bus.mem_we), 32'(we));
      check_val("beat_addr", bus.mem_addr, addr + 32'(k));
      check_val("beat_busy", 32'(bus.req_ready), 32'd0);
      if (we) check_val("beat_wdata", 32'(bus.mem_wdata), 32'(exp_wbytes[31-8*k -: 8]));
      @(negedge clk);
    end
    check_val("resp_valid", 32'(bus.resp_valid), 32'd1);
    check_val("resp_err",   32'(bus.resp_err), 32'(exp_err));
    check_val("resp_rdata", bus.resp_rdata, exp_rdata);
    check_val("resp_nostb", 32'({bus.mem_re, bus.mem_we}), 32'd0);
    $display("txn we=%0d f3=%03b addr=%08h -> err=%0d rdata=%08h", we, f3, addr,
             bus.resp_err, bus.resp_rdata);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_val("resp_pulse", 32'(bus.resp_valid), 32'd0);
    check_val("ready_back", 32'(bus.req_ready), 32'd1);
    check_val("rdata_hold", bus.resp_rdata, exp_rdata);
  endtask

  initial begin
    rst = 1'b1; pre_en = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_val("rst_ready", 32'(bus.req_ready), 32'd1);
    check_val("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    check_val("rst_err", 32'(bus.resp_err), 32'd0);
    check_val("rst_rdata", bus.resp_rdata, 32'h0);
    check_val("rst_strobes", 32'({bus.mem_re, bus.mem_we}), 32'd0);
    check_val("rst_maddr", bus.mem_addr, 32'h0);
    check_val("rst_mwdata", 32'(bus.mem_wdata), 32'h0);

    preload(8'h10, 8'h12); preload(8'h11, 8'h34); preload(8'h12, 8'h56); preload(8'h13, 8'h78);
    preload(8'h20, 8'h80); preload(8'h21, 8'h85); preload(8'h22, 8'h01);
    preload(8'h30, 8'h00); preload(8'h31, 8'h00);
    preload(8'hFE, 8'hA1); preload(8'hFF, 8'hB2); preload(8'h00, 8'hC3); preload(8'h01, 8'hD4);
    preload(8'h50, 8'h11); preload(8'h51, 8'h22); preload(8'h52, 8'h33); preload(8'h53, 8'h44);
    rst = 1'b0;
    @(negedge clk);

    run_req(1'b0, F3_LW,  32'h10, 32'h0, 4, 1'b0, 32'h12345678, 32'h0);
    run_req(1'b0, F3_LB,  32'h20, 32'h0, 1, 1'b0, 32'hFFFFFF80, 32'h0);
    run_req(1'b0, F3_LBU, 32'h20, 32'h0, 1, 1'b0, 32'h00000080, 32'h0);
    run_req(1'b0, F3_LH,  32'h20, 32'h0, 2, 1'b0, 32'hFFFF8085, 32'h0);
    run_req(1'b0, F3_LHU, 32'h20, 32'h0, 2, 1'b0, 32'h00008085, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_req(1'b0, F3_LH,  32'h21, 32'h0, 0, 1'b1, 32'h0, 32'h0);
    run_req(1'b0, F3_LW,  32'h41, 32'h0, 0, 1'b1, 32'h0, 32'h0);
    run_req(1'b0, F3_LW,  32'hFFFFFFFE, 32'h0, 0, 1'b1, 32'h0, 32'h0);
`else
    run_req(1'b0, F3_LH,  32'h21, 32'h0, 2, 1'b0, 32'hFFFF8501, 32'h0);
    run_req(1'b0, F3_LHU, 32'h21, 32'h0, 2, 1'b0, 32'h00008501, 32'h0);
    run_req(1'b0, F3_LW,  32'hFFFFFFFE, 32'h0, 4, 1'b0, 32'hA1B2C3D4, 32'h0);
`endif

    // Store half: big-endian byte order on the port.
    run_req(1'b1, F3_LH, 32'h30, 32'hDEADBEEF, 2, 1'b0, 32'h0, 32'hBEEF0000);
    check_val("sh_mem30", 32'(mem[8'h30]), 32'h0BE);
    check_val("sh_mem31", 32'(mem[8'h31]), 32'h0EF);

    // Illegal codes: error response at T+1, no beats.
    run_req(1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b1, 32'h0, 32'h0);
    run_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, 1'b1, 32'h0, 32'h0);
    check_val("ill_nowrite", 32'(mem[8'h10]), 32'h012);

    // Reset during the third beat of a word store.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_LW;
    bus.req_addr = 32'h50; bus.req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_val("rs_b0_addr", bus.mem_addr, 32'h50);
    check_val("rs_b0_data", 32'(bus.mem_wdata), 32'h0AA);
    @(negedge clk);
    check_val("rs_b1_addr", bus.mem_addr, 32'h51);
    check_val("rs_b1_data", 32'(bus.mem_wdata), 32'h0BB);
    @(negedge clk);
    check_val("rs_b2_addr", bus.mem_addr, 32'h52);
    check_val("rs_b2_we", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rs_strobes", 32'({bus.mem_re, bus.mem_we}), 32'd0);
    check_val("rs_rvalid", 32'(bus.resp_valid), 32'd0);
    check_val("rs_ready", 32'(bus.req_ready), 32'd1);
    check_val("rs_mem50", 32'(mem[8'h50]), 32'h0AA);
    check_val("rs_mem51", 32'(mem[8'h51]), 32'h0BB);
    check_val("rs_mem52", 32'(mem[8'h52]), 32'h033);
    check_val("rs_mem53", 32'(mem[8'h53]), 32'h044);
    @(negedge clk);
    check_val("rs_no_resp", 32'(bus.resp_valid), 32'd0);
    run_req(1'b0, F3_LB, 32'h50, 32'h0, 1, 1'b0, 32'hFFFFFFAA, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
